// File: rtl/serial_nibble_rx.sv
// ============================================================================
// Module   : serial_nibble_rx
// Purpose  : Oversampled start/stop serial byte receiver (MSB first) with
//            nibble split for two hex digits, valid/ack handshake, framing
//            error pulse and sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_nibble_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_in,
    input  logic       data_ack,
    output logic [7:0] byte_out,
    output logic [3:0] hex_hi,
    output logic [3:0] hex_lo,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int                 c_IDX_W     = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_rx_s;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0]   r_shreg;

    logic                   w_good_load;
    logic                   w_ack;

    // Synchronisers idle high so a reset never fakes a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_good_load = (r_state == S_STOP) && (r_cnt == c_BIT_LAST) && r_rx_s;
    assign w_ack       = data_ack && data_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            byte_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shreg <= {r_shreg[DATA_BITS-2:0], r_rx_s};
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    // A line held low must go high before a new start is accepted.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_good_load) begin
                byte_out   <= r_shreg[7:0];
                data_valid <= 1'b1;
                if (data_valid && !data_ack) begin
                    overrun <= 1'b1;
                end else if (w_ack) begin
                    overrun <= 1'b0;
                end
            end else if (w_ack) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

    assign hex_hi = byte_out[7:4];
    assign hex_lo = byte_out[3:0];

endmodule

`default_nettype wire

// File: tb/tb_serial_nibble_rx.sv
// ============================================================================
// Module   : tb_serial_nibble_rx
// Purpose  : Scoreboard bench for serial_nibble_rx with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_nibble_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] byte_out;
    logic [3:0] hex_hi;
    logic [3:0] hex_lo;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cycles = 0;
    int fe_pulses = 0;
    int lat;
    int fp0;
    int fc0;

    typedef struct packed {
        logic [7:0] b;
        logic       v;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];

    serial_nibble_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_in      (rx_in),
        .data_ack   (data_ack),
        .byte_out   (byte_out),
        .hex_hi     (hex_hi),
        .hex_lo     (hex_lo),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive(1'b0, CPB);
        for (int i = 7; i >= 0; i--) drive(b[i], CPB);
        drive(stop, CPB);
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic ov);
        exp_q.push_back({b, 1'b1, ov});
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        data_ack = 1'b0;
    endtask

    // Monitor: a load is seen as a byte change or a rising data_valid.
    initial begin : monitor
        logic [7:0] prev_b;
        logic       prev_v;
        logic       prev_fe;
        exp_t       e;
        prev_b  = 8'h00;
        prev_v  = 1'b0;
        prev_fe = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (frame_err) fe_cycles++;
                if (frame_err && !prev_fe) fe_pulses++;
                if (byte_out != prev_b || (data_valid && !prev_v)) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_load: got byte %02h, required no load", byte_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_byte_out",   32'(byte_out),   32'(e.b));
                        check("sb_hex_hi",     32'(hex_hi),     32'(e.b[7:4]));
                        check("sb_hex_lo",     32'(hex_lo),     32'(e.b[3:0]));
                        check("sb_data_valid", 32'(data_valid), 32'(e.v));
                        check("sb_overrun",    32'(overrun),    32'(e.ov));
                        check("sb_frame_err",  32'(frame_err),  32'(1'b0));
                    end
                end
            end
            prev_b  = byte_out;
            prev_v  = data_valid;
            prev_fe = frame_err;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_out",   32'(byte_out),   32'h00);
        check("rst_hex_hi",     32'(hex_hi),     32'h0);
        check("rst_hex_lo",     32'(hex_lo),     32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_frame_err",  32'(frame_err),  32'h0);
        check("rst_overrun",    32'(overrun),    32'h0);
        reset_n = 1'b1;
        drive(1'b1, 10);

        // 0xA5 with latency measured from the falling edge of rx_in
        fp0 = fe_pulses;
        expect_byte(8'hA5, 1'b0);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (lat < 400 && !data_valid) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check("a5_latency", 32'(lat), 32'd155);
            end
        join
        check("a5_no_frame_err", 32'(fe_pulses), 32'(fp0));
        drive(1'b1, 4);
        ack_pulse();
        check("a5_ack_valid", 32'(data_valid), 32'h0);

        // Short low glitch rejected in START
        drive(1'b0, 4);
        drive(1'b1, 40);
        check("glitch_byte_out",  32'(byte_out),   32'hA5);
        check("glitch_valid",     32'(data_valid), 32'h0);
        check("glitch_frame_err", 32'(fe_pulses),  32'(fp0));

        // 0x3C with bad stop, line held low afterwards
        fc0 = fe_cycles;
        send_frame(8'h3C, 1'b0);
        drive(1'b0, 40);
        drive(1'b1, 200);
        check("ferr_pulses",   32'(fe_pulses),  32'(fp0 + 1));
        check("ferr_cycles",   32'(fe_cycles),  32'(fc0 + 1));
        check("ferr_byte_out", 32'(byte_out),   32'hA5);
        check("ferr_valid",    32'(data_valid), 32'h0);
        check("ferr_overrun",  32'(overrun),    32'h0);

        // 0x12 then 0x34 without ack
        expect_byte(8'h12, 1'b0);
        send_frame(8'h12, 1'b1);
        drive(1'b1, 20);
        expect_byte(8'h34, 1'b1);
        send_frame(8'h34, 1'b1);
        drive(1'b1, 20);
        check("ovr_byte_out", 32'(byte_out),   32'h34);
        check("ovr_valid",    32'(data_valid), 32'h1);
        check("ovr_overrun",  32'(overrun),    32'h1);
        ack_pulse();
        check("ovr_ack_valid",   32'(data_valid), 32'h0);
        check("ovr_ack_overrun", 32'(overrun),    32'h0);

        // 0x55 held, then 0x7E loads in the same cycle as an ack
        expect_byte(8'h55, 1'b0);
        send_frame(8'h55, 1'b1);
        drive(1'b1, 20);
        expect_byte(8'h7E, 1'b0);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 data_ack = 1'b1;
                @(posedge clk);
                #1 data_ack = 1'b0;
            end
        join
        check("simul_byte_out", 32'(byte_out),   32'h7E);
        check("simul_valid",    32'(data_valid), 32'h1);
        check("simul_overrun",  32'(overrun),    32'h0);

        // Reset pulse during data bit 4 of 0xFF
        drive(1'b1, 20);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (88) @(posedge clk);
                #1 reset_n = 1'b0;
                #1;
                check("mid_rst_byte_out",  32'(byte_out),   32'h00);
                check("mid_rst_hex_hi",    32'(hex_hi),     32'h0);
                check("mid_rst_hex_lo",    32'(hex_lo),     32'h0);
                check("mid_rst_valid",     32'(data_valid), 32'h0);
                check("mid_rst_overrun",   32'(overrun),    32'h0);
                check("mid_rst_frame_err", 32'(frame_err),  32'h0);
                repeat (2) @(posedge clk);
                #1 reset_n = 1'b1;
            end
        join
        drive(1'b1, 20);
        check("post_rst_byte_out", 32'(byte_out),   32'h00);
        check("post_rst_valid",    32'(data_valid), 32'h0);

        expect_byte(8'h81, 1'b0);
        send_frame(8'h81, 1'b1);
        drive(1'b1, 30);
        check("r81_hex_hi", 32'(hex_hi),     32'h8);
        check("r81_hex_lo", 32'(hex_lo),     32'h1);
        check("r81_valid",  32'(data_valid), 32'h1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_nibble_rx.md
Name: serial_nibble_rx

Overview:
- Upstream stage of the hex display path.
- Receives an asynchronous serial byte stream, MSB first, with start and stop framing, sampled by an oversampling counter.
- Presents the received byte split into two 4-bit nibbles for two 7-segment decoders.
- Provides a valid/ack handshake plus framing-error and overrun status for the controlling logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.
DATA_BITS, 8, data bits per frame; fixed at 8 for nibble split, parameterised for shift/count logic only.

Ports:
clk  input  1  system clock, all state on rising edge.
reset_n  input  1  asynchronous, active-low reset.
rx_in  input  1  serial line; idle high, asynchronous to clk.
data_ack  input  1  consumer acknowledges current byte; sampled each cycle.
byte_out  output  8  last good received byte.
hex_hi  output  4  byte_out[7:4], drives upper digit decoder.
hex_lo  output  4  byte_out[3:0], drives lower digit decoder.
data_valid  output  1  byte_out holds an unacknowledged byte.
frame_err  output  1  one-cycle pulse on a bad stop bit.
overrun  output  1  sticky; an unacknowledged byte was overwritten.

Behaviour:
- Reset (reset_n=0, asynchronous) clears:
  - byte_out, hex_hi, hex_lo to 0;
  - data_valid, frame_err, overrun to 0;
  - shift register and counters to 0;
  - state to IDLE;
  - both synchroniser flops to 1.
- Reset mid-frame discards the partial frame. After release, a new frame needs a fresh high-to-low start edge.
- Synchroniser: rx_in passes through 2 flops; rx_s is the second flop. All decisions use rx_s only.
- State IDLE:
  - rx_s==0 -> START, clear cnt.
- State START:
  - Count to CLKS_PER_BIT/2-1, then sample rx_s.
  - rx_s==0 -> DATA, clear cnt and bit index.
  - rx_s==1 -> IDLE (glitch rejected, no outputs change).
- State DATA:
  - Count to CLKS_PER_BIT-1, then sample.
  - Shift left: shreg <= {shreg[DATA_BITS-2:0], rx_s}. The first received bit ends at byte bit 7.
  - After the DATA_BITS-th sample -> STOP.
- State STOP:
  - Count to CLKS_PER_BIT-1, then sample.
  - rx_s==1 -> load byte_out from shreg, go to IDLE.
  - rx_s==0 -> assert frame_err for exactly one cycle, byte_out unchanged, go to BREAK.
- State BREAK:
  - Wait until rx_s==1, then IDLE. A line held low is never reinterpreted as start bits.
- Timing: let t0 be the first cycle IDLE sees rx_s==0.
  - Data bit k (0..7) is sampled at t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - The stop bit is sampled at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - byte_out, hex_*, data_valid and frame_err update on the following edge (1-cycle registered latency).
  - rx_in to rx_s adds 2 cycles.
- hex_hi and hex_lo are always the combinational split of registered byte_out. They never show partial shift data.
- Handshake:
  - data_valid sets on a good load.
  - It clears on the edge after any cycle with data_ack=1 && data_valid=1.
  - data_ack while data_valid=0 is ignored.
- Simultaneous good load and ack in the same cycle: the new byte is loaded, data_valid stays 1, overrun is not set.
- Good load while data_valid=1 and no ack: the byte is overwritten and overrun is set. overrun clears together with data_valid on ack.
- A frame error never affects data_valid, byte_out or overrun.
- Back-to-back frames: IDLE may detect the next start edge on the cycle after the stop sample.

Test Plan:
- CLKS_PER_BIT=16. Send 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1) -> required response:
  - byte_out=8'hA5, hex_hi=4'hA, hex_lo=4'h5;
  - data_valid rises exactly 2+8+144+1=155 cycles after rx_in falls;
  - frame_err stays 0.
- Low pulse of 4 cycles on idle line -> returns to IDLE; data_valid, byte_out and frame_err unchanged.
- Frame 0x3C with stop bit 0, line held low 40 cycles -> required response:
  - frame_err high exactly 1 cycle; byte_out keeps its prior value;
  - no new start is detected until rx_in returns high.
- Frames 0x12 then 0x34, no ack -> byte_out=8'h34, data_valid=1, overrun=1. Pulse data_ack 1 cycle -> both 0 next cycle.
- data_ack asserted on the exact cycle the 0x7E load occurs while holding 0x55 -> byte_out=8'h7E, data_valid=1, overrun=0.
- reset_n pulsed low during data bit 4 of 0xFF -> all outputs 0 immediately; the next full frame 0x81 is received correctly (hex_hi=4'h8, hex_lo=4'h1).
